// File: rtl/counter_cmd_arbiter.sv
// Round-robin arbiter that shares one external W-bit counter between NREQ requesters.
// Define SATURATE_EN to suppress INC at all-ones and flag it with rsp_sat.
module counter_cmd_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              cnt_reset,
  output logic              cnt_load,
  output logic              cnt_enable,
  output logic [W-1:0]      cnt_data,
  input  logic [W-1:0]      cnt_value,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_count,
  output logic              rsp_sat
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam int         NEXT     = 1 << IDW;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_UPDATE, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   data_q, data_d;
  logic [W-1:0]   count_q, count_d;
  logic           sat_q, sat_d;

  logic [NEXT-1:0] valid_ext;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  gnt;
  logic            found;
  logic [NREQ-1:0] gnt_onehot;
  logic [1:0]      gnt_op;
  logic [W-1:0]    gnt_data;

  // Padding to 2**IDW lets the rotating search index with a full IDW-bit value.
  assign valid_ext = NEXT'(req_valid);

  always_comb begin
    cand       = '0;
    gnt        = '0;
    found      = 1'b0;
    gnt_onehot = '0;
    gnt_op     = OP_READ;
    gnt_data   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && valid_ext[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (found && gnt == IDW'(i)) begin
        gnt_onehot[i] = 1'b1;
        gnt_op        = req_op[2*i +: 2];
        gnt_data      = req_data[W*i +: W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    data_d     = data_q;
    count_d    = count_q;
    sat_d      = sat_q;
    req_ready  = '0;
    cnt_reset  = 1'b0;
    cnt_load   = 1'b0;
    cnt_enable = 1'b0;
    cnt_data   = '0;
    rsp_valid  = 1'b0;
    rsp_sat    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          // A grant offered while reset is low would be lost, so it is withheld.
          req_ready = gnt_onehot & {NREQ{reset}};
          state_d   = S_ISSUE;
          ptr_d     = gnt;
          id_d      = gnt;
          op_d      = gnt_op;
          data_d    = gnt_data;
`ifdef SATURATE_EN
          sat_d     = (gnt_op == OP_INC) && (cnt_value == {W{1'b1}});
`else
          sat_d     = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        case (op_q)
          OP_CLEAR: cnt_reset = 1'b1;
          OP_LOAD: begin
            cnt_load = 1'b1;
            cnt_data = data_q;
          end
          OP_INC:   cnt_enable = !sat_q;
          default:  ;
        endcase
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        count_d = cnt_value;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_sat   = sat_q;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      op_q    <= OP_READ;
      data_q  <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      data_q  <= data_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign rsp_id    = id_q;
  assign rsp_count = count_q;

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Directed bench for counter_cmd_arbiter with a behavioural 8-bit counter attached.
module tb_counter_cmd_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam logic [1:0] READ = 2'b00, INC = 2'b01, LOAD = 2'b10, CLEAR = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              cnt_reset, cnt_load, cnt_enable;
  logic [W-1:0]      cnt_data;
  logic [W-1:0]      ctr = 8'h00;
  logic              rsp_valid, rsp_ready, rsp_sat;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_count;

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;

  counter_cmd_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
    .cnt_reset(cnt_reset), .cnt_load(cnt_load), .cnt_enable(cnt_enable),
    .cnt_data(cnt_data), .cnt_value(ctr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_count(rsp_count), .rsp_sat(rsp_sat)
  );

  always #5 clk = ~clk;

  // The shared smartcounter: sync active-high clear, load, enable.
  always @(posedge clk) begin
    if (cnt_reset)       ctr <= 8'h00;
    else if (cnt_load)   ctr <= cnt_data;
    else if (cnt_enable) ctr <= ctr + 8'd1;
  end

  always @(negedge clk) begin
    if ($countones({cnt_reset, cnt_load, cnt_enable}) > 1 || (!cnt_load && cnt_data != 8'h00))
      viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] d);
    req_op[2*i +: 2]   = op;
    req_data[8*i +: 8] = d;
  endtask

  // Checks the one-hot accept in the current IDLE cycle, then lets it be taken.
  task automatic grant(input string tag, input logic [3:0] exp_rdy, input logic [3:0] valid_after);
    @(negedge clk);
    check_eq({tag, "_rdy"}, req_ready, exp_rdy);
    step();
    req_valid = valid_after;
  endtask

  task automatic issue_chk(input string tag, input logic [2:0] exp_strb, input logic [7:0] exp_dat);
    @(negedge clk);
    check_eq({tag, "_strb"}, {cnt_reset, cnt_load, cnt_enable}, exp_strb);
    check_eq({tag, "_dat"}, cnt_data, exp_dat);
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] id, input logic [7:0] cnt, input logic sat);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) begin
      check_eq({tag, "_timeout"}, 0, 1);
    end else begin
      check_eq({tag, "_id"}, rsp_id, id);
      check_eq({tag, "_cnt"}, rsp_count, cnt);
      check_eq({tag, "_sat"}, rsp_sat, sat);
    end
    step();
  endtask

  initial begin
    int rsp_seen;
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    reset     = 1'b0;
    step();
    step();
    @(negedge clk);
    check_eq("rst_rdy", req_ready, 0);
    check_eq("rst_strb", {cnt_reset, cnt_load, cnt_enable, cnt_data}, 0);
    check_eq("rst_rsp", {rsp_valid, rsp_sat, rsp_id, rsp_count}, 0);
    step();
    reset = 1'b1;

    // Single INC from requester 0.
    set_req(0, INC, 8'h00);
    req_valid = 4'b0001;
    grant("t1", 4'b0001, 4'b0000);
    issue_chk("t1", 3'b001, 8'h00);
    wait_rsp("t1", 2'd0, 8'h01, 1'b0);

    // Fresh pointer, counter already at 1: all four INC held valid.
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, INC, 8'h00);
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      grant($sformatf("t2_%0d", j), 4'b0001 << (j % 4), (j == 4) ? 4'b0000 : 4'b1111);
      wait_rsp($sformatf("t2_%0d", j), 2'(j % 4), 8'(2 + j), 1'b0);
    end

    // LOAD then READ.
    set_req(2, LOAD, 8'hA5);
    req_valid = 4'b0100;
    grant("t3_load", 4'b0100, 4'b0000);
    issue_chk("t3_load", 3'b010, 8'hA5);
    wait_rsp("t3_load", 2'd2, 8'hA5, 1'b0);
    set_req(1, READ, 8'h00);
    req_valid = 4'b0010;
    grant("t3_read", 4'b0010, 4'b0000);
    issue_chk("t3_read", 3'b000, 8'h00);
    wait_rsp("t3_read", 2'd1, 8'hA5, 1'b0);

    // INC at all-ones.
    set_req(3, LOAD, 8'hFF);
    req_valid = 4'b1000;
    grant("t4_load", 4'b1000, 4'b0000);
    wait_rsp("t4_load", 2'd3, 8'hFF, 1'b0);
    set_req(3, INC, 8'h00);
    req_valid = 4'b1000;
    grant("t4_inc", 4'b1000, 4'b0000);
`ifdef SATURATE_EN
    issue_chk("t4_inc", 3'b000, 8'h00);
    wait_rsp("t4_inc", 2'd3, 8'hFF, 1'b1);
`else
    issue_chk("t4_inc", 3'b001, 8'h00);
    wait_rsp("t4_inc", 2'd3, 8'h00, 1'b0);
`endif

    // Response backpressure with requester 1 waiting.
    rsp_ready = 1'b0;
    set_req(0, LOAD, 8'h3C);
    req_valid = 4'b0001;
    grant("t5", 4'b0001, 4'b0000);
    set_req(1, READ, 8'h00);
    req_valid = 4'b0010;
    wait_rsp("t5", 2'd0, 8'h3C, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("t5_hold%0d", k), {rsp_valid, rsp_id, rsp_count, req_ready},
               {1'b1, 2'd0, 8'h3C, 4'b0000});
    end
    step();
    rsp_ready = 1'b1;
    step();
    check_eq("t5_rsp_drop", rsp_valid, 0);
    grant("t5_after", 4'b0010, 4'b0000);
    wait_rsp("t5_read", 2'd1, 8'h3C, 1'b0);

    // Reset during ISSUE of a CLEAR.
    set_req(2, CLEAR, 8'h00);
    req_valid = 4'b0100;
    grant("t6", 4'b0100, 4'b0000);
    reset = 1'b0;
    issue_chk("t6_issue", 3'b100, 8'h00);
    step();
    @(negedge clk);
    check_eq("t6_after_rst", {cnt_reset, cnt_load, cnt_enable, rsp_valid, req_ready}, 0);
    step();
    reset = 1'b1;
    rsp_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    check_eq("t6_no_rsp", rsp_seen, 0);
    step();
    set_req(0, INC, 8'h00);
    set_req(3, INC, 8'h00);
    req_valid = 4'b1001;
    grant("t6_next", 4'b0001, 4'b0000);
    wait_rsp("t6_inc", 2'd0, 8'h01, 1'b0);

    check_eq("strobe_rules", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
